// File: rtl/vga_capture_mod.sv
// VGA receiver: samples RGB/sync pins on pixel-enable ticks, recovers timing,
// and emits an 8-bit-per-channel pixel stream with x/y coordinates once locked.
module vga_capture_mod #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_ACT = 1'b0
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_i,
    input  logic       pix_en_i,
    input  logic [3:0] red_i,
    input  logic [3:0] green_i,
    input  logic [3:0] blue_i,
    input  logic       hsync_i,
    input  logic       vsync_i,
    output logic       pix_valid_o,
    output logic [9:0] pix_x_o,
    output logic [9:0] pix_y_o,
    output logic [7:0] red_o,
    output logic [7:0] green_o,
    output logic [7:0] blue_o,
    output logic       frame_start_o,
    output logic       locked_o,
    output logic       err_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_LO   = 11'(H_START);
    localparam logic [10:0] H_HI   = 11'(H_START + H_ACTIVE);
    localparam logic [9:0]  V_LO   = 10'(V_START);
    localparam logic [9:0]  V_HI   = 10'(V_START + V_ACTIVE);
    localparam logic [9:0]  V_TOT  = 10'(V_TOTAL);

    typedef enum logic [1:0] {HUNT, MEASURE, LOCKED} state_t;
    state_t r_state, w_state_next;

    logic        r_hs_prev, r_vs_prev;
    logic [10:0] r_h_cnt, w_h_next;
    logic [9:0]  r_v_cnt, w_v_next;
    logic [9:0]  r_line_cnt, w_line_next;
    logic        r_meas_ok, w_meas_ok_next;
    logic        r_err, w_err_set;
    logic        w_hs_act, w_vs_act, w_hs_lead, w_vs_lead;
    logic        w_line_bad, w_frame_bad, w_active;
    logic [9:0]  w_x, w_y;

    assign w_hs_act    = (hsync_i == SYNC_ACT);
    assign w_vs_act    = (vsync_i == SYNC_ACT);
    assign w_hs_lead   = pix_en_i && w_hs_act && !r_hs_prev;
    assign w_vs_lead   = pix_en_i && w_vs_act && !r_vs_prev;
    // A line ending on hs_lead is good when the counter reached exactly H_TOTAL-1.
    assign w_line_bad  = w_hs_lead && (r_h_cnt != H_LAST);
    assign w_frame_bad = w_vs_lead && (r_line_cnt != V_TOT);

    always_comb begin
        w_h_next    = r_h_cnt;
        w_v_next    = r_v_cnt;
        w_line_next = r_line_cnt;
        if (w_hs_lead) begin
            w_h_next = '0;
        end else if (r_h_cnt != '1) begin
            w_h_next = r_h_cnt + 11'd1;
        end
        if (w_vs_lead) begin
            w_v_next = '0;
        end else if (w_hs_lead && r_v_cnt != '1) begin
            w_v_next = r_v_cnt + 10'd1;
        end
        // A coincident hs_lead opens the new frame, so it seeds the line count.
        if (w_vs_lead) begin
            w_line_next = {9'd0, w_hs_lead};
        end else if (w_hs_lead && r_line_cnt != '1) begin
            w_line_next = r_line_cnt + 10'd1;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_meas_ok_next = r_meas_ok;
        w_err_set      = 1'b0;
        case (r_state)
            HUNT: begin
                if (w_vs_lead) begin
                    w_state_next   = MEASURE;
                    w_meas_ok_next = 1'b1;
                end
            end
            MEASURE: begin
                if (w_vs_lead) begin
                    w_meas_ok_next = 1'b1;
                    if (r_meas_ok && !w_line_bad && !w_frame_bad) begin
                        w_state_next = LOCKED;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end else if (w_line_bad) begin
                    w_meas_ok_next = 1'b0;
                    w_err_set      = 1'b1;
                end
            end
            LOCKED: begin
                if (w_line_bad || w_frame_bad) begin
                    w_state_next = HUNT;
                    w_err_set    = 1'b1;
                end
            end
            default: w_state_next = HUNT;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_x      = 10'(w_h_next - H_LO);
    assign w_y      = 10'(w_v_next - V_LO);
    assign w_active = pix_en_i && (r_state == LOCKED) &&
                      (w_h_next >= H_LO) && (w_h_next < H_HI) &&
                      (w_v_next >= V_LO) && (w_v_next < V_HI);

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            r_hs_prev     <= 1'b0;
            r_vs_prev     <= 1'b0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_line_cnt    <= '0;
            r_meas_ok     <= 1'b0;
            r_err         <= 1'b0;
            pix_valid_o   <= 1'b0;
            frame_start_o <= 1'b0;
            pix_x_o       <= '0;
            pix_y_o       <= '0;
            red_o         <= '0;
            green_o       <= '0;
            blue_o        <= '0;
        end else begin
            r_meas_ok     <= w_meas_ok_next;
            pix_valid_o   <= w_active;
            frame_start_o <= w_active && (w_x == '0) && (w_y == '0);
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (pix_en_i) begin
                r_hs_prev  <= w_hs_act;
                r_vs_prev  <= w_vs_act;
                r_h_cnt    <= w_h_next;
                r_v_cnt    <= w_v_next;
                r_line_cnt <= w_line_next;
            end
            if (w_active) begin
                pix_x_o <= w_x;
                pix_y_o <= w_y;
                red_o   <= {red_i, red_i};
                green_o <= {green_i, green_i};
                blue_o  <= {blue_i, blue_i};
            end
        end
    end

    assign locked_o = (r_state == LOCKED);
    assign err_o    = r_err;

endmodule

// File: tb/tb_vga_capture_mod.sv
// Scoreboard bench for vga_capture_mod using a reduced 16x11 raster so that
// whole frames (lock, loss of lock, relock) fit in a short run.
module tb_vga_capture_mod;
    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6, VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int HST = HS + HB;
    localparam int VST = VS + VB;
    localparam logic ACT = 1'b0;

    logic       clk = 1'b0, rst_n = 1'b0, pix_en = 1'b0;
    logic [3:0] red = '0, green = '0, blue = '0;
    logic       hsync = 1'b1, vsync = 1'b1;
    logic       pix_valid_o, frame_start_o, locked_o, err_o;
    logic [9:0] pix_x_o, pix_y_o;
    logic [7:0] red_o, green_o, blue_o;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] red;
        logic [7:0] grn;
        logic [7:0] blu;
        logic       fs;
    } pix_t;

    pix_t exp_q[$];
    int   errors = 0, checks = 0, n_seen = 0;

    vga_capture_mod #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_ACT(1'b0)
    ) dut (
        .sys_clk_i(clk), .sys_rst_i(rst_n), .pix_en_i(pix_en),
        .red_i(red), .green_i(green), .blue_i(blue),
        .hsync_i(hsync), .vsync_i(vsync),
        .pix_valid_o(pix_valid_o), .pix_x_o(pix_x_o), .pix_y_o(pix_y_o),
        .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
        .frame_start_o(frame_start_o), .locked_o(locked_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented pixel must match the head of the expectation queue.
    always @(negedge clk) begin
        pix_t e;
        if (pix_valid_o) begin
            n_seen++;
            if (exp_q.size() == 0) begin
                chk("pix_unexpected", 64'(pix_valid_o), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pixel", 64'({pix_x_o, pix_y_o, red_o, green_o, blue_o, frame_start_o}), 64'(e));
            end
        end else if (frame_start_o) begin
            chk("fs_without_valid", 64'(frame_start_o), 64'd0);
        end
    end

    task automatic do_reset(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (i > 0) chk("reset_outputs", 64'({pix_valid_o, pix_x_o, pix_y_o, red_o, green_o,
                                                 blue_o, frame_start_o, locked_o, err_o}), 64'd0);
            rst_n  = 1'b0;
            pix_en = 1'($urandom);
            red = 4'($urandom); green = 4'($urandom); blue = 4'($urandom);
            hsync = 1'($urandom); vsync = 1'($urandom);
        end
        @(negedge clk);
        chk("reset_outputs", 64'({pix_valid_o, pix_x_o, pix_y_o, red_o, green_o,
                                  blue_o, frame_start_o, locked_o, err_o}), 64'd0);
        rst_n = 1'b1; pix_en = 1'b0; hsync = ~ACT; vsync = ~ACT;
    endtask

    // One pixel sample followed by a strobe gap with junk on the pins.
    task automatic samp(input logic hs, input logic vs, input logic [3:0] rr,
                        input logic [3:0] gg, input logic [3:0] bb, input bit irr,
                        input bit do_chk, input logic [1:0] exp_le);
        int gap;
        @(negedge clk);
        pix_en = 1'b1; hsync = hs; vsync = vs; red = rr; green = gg; blue = bb;
        gap = irr ? int'($urandom_range(7, 1)) : 3;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            if (i == 0 && do_chk) chk("lock_err", 64'({locked_o, err_o}), 64'(exp_le));
            pix_en = 1'b0;
            red = 4'($urandom); green = 4'($urandom); blue = 4'($urandom);
            hsync = 1'($urandom); vsync = 1'($urandom);
        end
    endtask

    // Lines below cap_lines are expected to be captured; hs and vs lead together at line 0.
    task automatic drive_frame(input int nlines, input int short_line, input int short_len,
                               input int cap_lines, input int chk_line, input logic [1:0] chk_le,
                               input bit irr, input int rst_line);
        int seen0, n_exp, len;
        logic [3:0] rr, gg, bb;
        pix_t e;
        seen0 = n_seen;
        n_exp = 0;
        for (int l = 0; l < nlines; l++) begin
            len = (l == short_line) ? short_len : HT;
            for (int h = 0; h < len; h++) begin
                if (l == rst_line && h == 0) do_reset(1);
                rr = 4'($urandom); gg = 4'($urandom); bb = 4'($urandom);
                if (l < cap_lines && h >= HST && h < HST + HA && l >= VST && l < VST + VA) begin
                    e.x = 10'(h - HST);
                    e.y = 10'(l - VST);
                    e.red = {rr, rr}; e.grn = {gg, gg}; e.blu = {bb, bb};
                    e.fs = (h == HST) && (l == VST);
                    exp_q.push_back(e);
                    n_exp++;
                end
                samp((h < HS) ? ACT : ~ACT, (l < VS) ? ACT : ~ACT, rr, gg, bb, irr,
                     (l == chk_line) && (h == 0), chk_le);
            end
        end
        chk("frame_pixels", 64'(n_seen - seen0), 64'(n_exp));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        do_reset(3);
        for (int i = 0; i < 20; i++)
            samp(~ACT, ~ACT, 4'($urandom), 4'($urandom), 4'($urandom), 1'b0, i == 19, 2'b00);

        // Clean frames: lock one clock after the second vs_lead.
        drive_frame(VT, -1, 0, 0,  0, 2'b00, 1'b0, -1);
        drive_frame(VT, -1, 0, VT, 0, 2'b10, 1'b0, -1);
        drive_frame(VT, -1, 0, VT, 0, 2'b10, 1'b0, -1);

        // Short line while locked, then relock two frames later.
        drive_frame(VT, 6, HT - 1, 7, 7, 2'b01, 1'b0, -1);
        drive_frame(VT, -1, 0, 0,  0, 2'b01, 1'b0, -1);
        drive_frame(VT, -1, 0, VT, 0, 2'b11, 1'b0, -1);

        // Reset mid-frame clears err and needs one full frame to relock.
        drive_frame(VT, -1, 0, 6,  0, 2'b11, 1'b0, 6);
        drive_frame(VT, -1, 0, 0,  0, 2'b00, 1'b0, -1);
        drive_frame(VT, -1, 0, VT, 0, 2'b10, 1'b0, -1);

        // Short frame during MEASURE: no lock, err set; a good frame then locks.
        do_reset(1);
        drive_frame(VT - 1, -1, 0, 0, 0, 2'b00, 1'b0, -1);
        drive_frame(VT, -1, 0, 0,  0, 2'b01, 1'b0, -1);
        drive_frame(VT, -1, 0, VT, 0, 2'b11, 1'b0, -1);

        // Irregular strobe gaps must give identical pixels and coordinates.
        drive_frame(VT, -1, 0, VT, 0, 2'b11, 1'b1, -1);
        drive_frame(VT, -1, 0, VT, 0, 2'b11, 1'b1, -1);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
